// File: rtl/spi_tx_sched.sv
// Round-robin scheduler that shares one SPI byte transmitter among NUM_REQ requesters.
// Each frame is a grant, a start strobe, a done/timeout wait, an acknowledge and an inter-frame gap.
//
// state  | meaning
// IDLE   | arbitrate pending requests and latch the winner's frame
// LAUNCH | one-cycle m_start to the transmitter
// WAIT   | wait for m_done, aborted once the wait counter reaches TIMEOUT-1
// GAP    | ack cycle plus idle cycles that keep CS high between frames
module spi_tx_sched #(
   parameter int NUM_REQ = 4,
   parameter int GAP_CYC = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ*8-1:0] req_width,
   input  logic [NUM_REQ*2-1:0] req_cmd,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 ack_err,
   output logic                 m_start,
   output logic [7:0]           m_data,
   output logic [7:0]           m_width,
   output logic [1:0]           m_cmd,
   input  logic                 m_done,
   output logic                 busy,
   output logic [2:0]           grant_id,
   output logic                 err_timeout,
   input  logic                 clr_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [GW-1:0]      GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [2:0]         LAST_ID  = 3'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

   state_t        state;
   logic [2:0]    rr_ptr;
   logic [CW-1:0] wait_cnt;
   logic [GW-1:0] gap_cnt;

   logic [7:0] req_pad;
   logic [3:0] idx;
   logic       win_vld;
   logic [2:0] win_id;
   logic [7:0] sel_data;
   logic [7:0] sel_width;
   logic [1:0] sel_cmd;

   assign req_pad = 8'(req);

   // First pending requester at or after rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + 4'(i);
         if (idx >= 4'(NUM_REQ))
            idx = idx - 4'(NUM_REQ);
         if (!win_vld && req_pad[idx[2:0]]) begin
            win_vld = 1'b1;
            win_id  = idx[2:0];
         end
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_width = '0;
      sel_cmd   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_id == 3'(j)) begin
            sel_data  = req_data[j*8 +: 8];
            sel_width = req_width[j*8 +: 8];
            sel_cmd   = req_cmd[j*2 +: 2];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         wait_cnt    <= '0;
         gap_cnt     <= '0;
         ack         <= '0;
         ack_err     <= 1'b0;
         m_start     <= 1'b0;
         m_data      <= '0;
         m_width     <= '0;
         m_cmd       <= '0;
         busy        <= 1'b0;
         grant_id    <= '0;
         err_timeout <= 1'b0;
      end else begin
         m_start <= 1'b0;
         ack     <= '0;
         ack_err <= 1'b0;
         // A timeout on this same edge overrides the clear further down.
         if (clr_err)
            err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state    <= LAUNCH;
                  busy     <= 1'b1;
                  m_start  <= 1'b1;
                  grant_id <= win_id;
                  m_data   <= sel_data;
                  m_width  <= sel_width;
                  m_cmd    <= sel_cmd;
               end
            end
            LAUNCH: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (m_done || wait_cnt == CNT_LAST) begin
                  ack     <= ONE << grant_id;
                  ack_err <= !m_done;
                  if (!m_done)
                     err_timeout <= 1'b1;
                  rr_ptr  <= (grant_id == LAST_ID) ? 3'd0 : grant_id + 3'd1;
                  if (GAP_CYC == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= GAP_LAST;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
